// File: rtl/lstm_gate_scheduler.sv
// Sequences the shared MAC datapath through the i/f/g/o gates of every hidden unit.
// Optional macro STALL_CNT_EN adds a saturating 16-bit stall/backpressure cycle counter.
module lstm_gate_scheduler #(
    parameter int X_LEN    = 8,
    parameter int H_LEN    = 8,
    parameter int W_ADDR_W = 10,
    parameter int V_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                mac_en,
    output logic                mux_mult_sel,
    output logic                mux_acc_sel,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic [V_ADDR_W-1:0] v_addr,
    output logic [1:0]          gate_sel,
    output logic [V_ADDR_W-1:0] unit_idx,
    output logic                gate_valid
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BIAS  = 3'd1;
    localparam logic [2:0] S_MAC_X = 3'd2;
    localparam logic [2:0] S_MAC_H = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [V_ADDR_W-1:0] X_LAST = V_ADDR_W'(X_LEN - 1);
    localparam logic [V_ADDR_W-1:0] H_LAST = V_ADDR_W'(H_LEN - 1);

    logic [2:0]          state_q, state_d;
    logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [V_ADDR_W-1:0] v_addr_q, v_addr_d;
    logic [1:0]          gate_q, gate_d;
    logic [V_ADDR_W-1:0] unit_q, unit_d;
    logic                active;

    assign active = (state_q == S_BIAS) || (state_q == S_MAC_X) || (state_q == S_MAC_H);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d  = state_q;
        w_addr_d = w_addr_q;
        v_addr_d = v_addr_q;
        gate_d   = gate_q;
        unit_d   = unit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BIAS;
                    w_addr_d = '0;
                    v_addr_d = '0;
                    gate_d   = '0;
                    unit_d   = '0;
                end
            end
            S_BIAS: begin
                if (!stall) begin
                    w_addr_d = w_addr_q + W_ADDR_W'(1);
                    v_addr_d = '0;
                    state_d  = S_MAC_X;
                end
            end
            S_MAC_X: begin
                if (!stall) begin
                    w_addr_d = w_addr_q + W_ADDR_W'(1);
                    if (v_addr_q == X_LAST) begin
                        v_addr_d = '0;
                        state_d  = S_MAC_H;
                    end else begin
                        v_addr_d = v_addr_q + V_ADDR_W'(1);
                    end
                end
            end
            S_MAC_H: begin
                if (!stall) begin
                    w_addr_d = w_addr_q + W_ADDR_W'(1);
                    if (v_addr_q == H_LAST) begin
                        v_addr_d = '0;
                        state_d  = S_EMIT;
                    end else begin
                        v_addr_d = v_addr_q + V_ADDR_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (gate_q != 2'd3) begin
                        gate_d  = gate_q + 2'd1;
                        state_d = S_BIAS;
                    end else begin
                        gate_d = '0;
                        // Last unit keeps its index; the timestep simply ends.
                        if (unit_q == H_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            unit_d  = unit_q + V_ADDR_W'(1);
                            state_d = S_BIAS;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            w_addr_q <= '0;
            v_addr_q <= '0;
            gate_q   <= '0;
            unit_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q  <= state_d;
            w_addr_q <= w_addr_d;
            v_addr_q <= v_addr_d;
            gate_q   <= gate_d;
            unit_q   <= unit_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (((active && stall) || ((state_q == S_EMIT) && !out_ready)) &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // Everything except the stall gating of mac_en is a decode of registered state.
    assign busy         = active || (state_q == S_EMIT);
    assign done         = (state_q == S_DONE);
    assign mac_en       = active && !stall;
    assign mux_mult_sel = (state_q == S_MAC_H);
    assign mux_acc_sel  = (state_q == S_BIAS);
    assign gate_valid   = (state_q == S_EMIT);
    assign w_addr       = w_addr_q;
    assign v_addr       = v_addr_q;
    assign gate_sel     = gate_q;
    assign unit_idx     = unit_q;

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Scoreboard bench for lstm_gate_scheduler: a reference model queues the expected MAC
// beats and gate results per timestep; a monitor pops and compares as the DUT presents them.
module tb_lstm_gate_scheduler;

    localparam int X_LEN    = 8;
    localparam int H_LEN    = 8;
    localparam int W_ADDR_W = 10;
    localparam int V_ADDR_W = 4;

    typedef struct {
        logic [W_ADDR_W-1:0] w;
        logic [V_ADDR_W-1:0] v;
        logic                msel;
        logic                asel;
    } beat_t;

    typedef struct {
        logic [V_ADDR_W-1:0] u;
        logic [1:0]          g;
        logic [W_ADDR_W-1:0] w;
    } gate_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic out_ready = 1'b1;
    logic busy, done, mac_en, mux_mult_sel, mux_acc_sel, gate_valid;
    logic [W_ADDR_W-1:0] w_addr;
    logic [V_ADDR_W-1:0] v_addr, unit_idx;
    logic [1:0]          gate_sel;
`ifdef STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    lstm_gate_scheduler #(
        .X_LEN(X_LEN), .H_LEN(H_LEN), .W_ADDR_W(W_ADDR_W), .V_ADDR_W(V_ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .busy(busy), .done(done), .mac_en(mac_en), .mux_mult_sel(mux_mult_sel),
        .mux_acc_sel(mux_acc_sel), .w_addr(w_addr), .v_addr(v_addr), .gate_sel(gate_sel),
        .unit_idx(unit_idx), .gate_valid(gate_valid)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    compared = 0;
    int    mismatched = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    exp_lat = -1;
    int    done_seen = 0;
    beat_t mac_q[$];
    gate_t gate_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: weights laid out as [unit][gate][bias, x..., h...].
    task automatic push_timestep();
        int wa = 0;
        for (int u = 0; u < H_LEN; u++) begin
            for (int g = 0; g < 4; g++) begin
                mac_q.push_back('{W_ADDR_W'(wa), '0, 1'b0, 1'b1});
                wa++;
                for (int i = 0; i < X_LEN; i++) begin
                    mac_q.push_back('{W_ADDR_W'(wa), V_ADDR_W'(i), 1'b0, 1'b0});
                    wa++;
                end
                for (int i = 0; i < H_LEN; i++) begin
                    mac_q.push_back('{W_ADDR_W'(wa), V_ADDR_W'(i), 1'b1, 1'b0});
                    wa++;
                end
                gate_q.push_back('{V_ADDR_W'(u), 2'(g), W_ADDR_W'(wa)});
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mac_en) begin
                if (mac_q.size() == 0) begin
                    check("mac_unexpected", 32'(mac_en), 32'd0);
                end else begin
                    beat_t b;
                    b = mac_q.pop_front();
                    check("mac_beat", 32'({w_addr, v_addr, mux_mult_sel, mux_acc_sel}),
                          32'({b.w, b.v, b.msel, b.asel}));
                end
            end
            if (gate_valid && out_ready) begin
                if (gate_q.size() == 0) begin
                    check("gate_unexpected", 32'(gate_valid), 32'd0);
                end else begin
                    gate_t e;
                    e = gate_q.pop_front();
                    check("gate_result", 32'({unit_idx, gate_sel, w_addr, mac_en}),
                          32'({e.u, e.g, e.w, 1'b0}));
                end
            end
            if (done) begin
                done_seen++;
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_gates_left", 32'(gate_q.size() + mac_q.size()), 32'd0);
                if (exp_lat >= 0) check("done_latency", 32'(cyc - t0 + 1), 32'(exp_lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        push_timestep();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 5000 && done_seen < target; i++) step();
        check("done_reached", 32'(done_seen), 32'(target));
    endtask

    initial begin
        int target;
        int cnt;

        #12;
        check("reset_outputs", 32'({busy, done, mac_en, mux_mult_sel, mux_acc_sel, w_addr,
                                    v_addr, gate_sel, unit_idx, gate_valid}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Plain timestep; also a start pulse on the DONE cycle that must be ignored.
        exp_lat = X_LEN + H_LEN + 2 == 18 ? 577 : -1;
        target = done_seen + 1;
        do_start();
        repeat (576) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_seen_once", 32'(done_seen), 32'(target));
        repeat (20) step();
        check("final_w_addr", 32'(w_addr), 32'd544);
        check("idle_after_done", 32'({busy, done, done_seen}), 32'(target));

        // Stall for 5 cycles while MAC_X sits at v_addr=3.
        exp_lat = 582;
        target = done_seen + 1;
        do_start();
        repeat (4) step();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_hold", 32'({mac_en, v_addr, w_addr}), 32'({1'b0, 4'd3, 10'd4}));
            step();
        end
        stall = 1'b0;
        wait_done(target);
`ifdef STALL_CNT_EN
        step();
        check("stall_cnt_stall", 32'(stall_cnt), 32'd5);
`endif
        repeat (3) step();

        // Backpressure on gate 3 of unit 0.
        exp_lat = 587;
        target = done_seen + 1;
        do_start();
        repeat (71) step();
        out_ready = 1'b0;
        cnt = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            cnt += int'(gate_valid);
            step();
            if (k == 9) out_ready = 1'b1;
        end
        check("gate_valid_held", 32'(cnt), 32'd11);
        @(negedge clk);
        check("next_unit_bias", 32'({gate_valid, mux_acc_sel, unit_idx, gate_sel, w_addr}),
              32'({1'b0, 1'b1, 4'd1, 2'd0, 10'd68}));
        wait_done(target);
`ifdef STALL_CNT_EN
        step();
        check("stall_cnt_backpressure", 32'(stall_cnt), 32'd10);
`endif
        repeat (3) step();

        // Asynchronous reset during MAC_H of unit 2 aborts without a done pulse.
        exp_lat = -1;
        target = done_seen;
        do_start();
        repeat (155) step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({busy, done, mac_en, mux_mult_sel, mux_acc_sel, w_addr,
                                    v_addr, gate_sel, unit_idx, gate_valid}), 32'd0);
        mac_q.delete();
        gate_q.delete();
        repeat (3) step();
        check("abort_no_done", 32'(done_seen), 32'(target));
        @(negedge clk) rst_n = 1'b1;
        step();
        exp_lat = 577;
        target = done_seen + 1;
        do_start();
        wait_done(target);
        repeat (3) step();

        // Randomized stall / backpressure with start pulses while busy.
        exp_lat = -1;
        for (int r = 0; r < 4; r++) begin
            target = done_seen + 1;
            do_start();
            for (int i = 0; i < 5000 && done_seen < target; i++) begin
                stall     = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 15) == 0);
                step();
            end
            start = 1'b0;
            stall = 1'b0;
            out_ready = 1'b1;
            check("rand_done", 32'(done_seen), 32'(target));
            repeat (5) step();
            check("rand_idle", 32'({busy, done_seen}), 32'(target));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
